// File: rtl/commit_rob.sv
// In-order reorder buffer for the commit stage.
// Collects out-of-order writebacks and retires on a prefix ack.
package commit_rob_pkg;
  localparam int XLEN = 32;
  localparam int ROB_DEPTH = 8;
  localparam int TRANS_ID_BITS = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic       valid;
    logic [4:0] cause;
  } exception_t;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [6:0]               op;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

module commit_rob
  import commit_rob_pkg::*;
#(
  parameter int NR_ENTRIES      = ROB_DEPTH,
  parameter int NR_COMMIT_PORTS = 2,
  parameter int NR_WB_PORTS     = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  input  logic                                      issue_valid_i,
  input  scoreboard_entry_t                         issue_instr_i,
  output logic                                      issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]              wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]   commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                commit_ack_i,
  output logic                                      empty_o
);

  localparam int TB = TRANS_ID_BITS;
  localparam int CW = TB + 1;

  scoreboard_entry_t r_mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] r_busy;
  logic [NR_ENTRIES-1:0] r_done;
  logic [TB-1:0]         r_head;
  logic [TB-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic [NR_COMMIT_PORTS-1:0][TB-1:0] w_idx;
  logic [NR_COMMIT_PORTS-1:0]         w_cval;
  logic [NR_COMMIT_PORTS-1:0]         w_ret;
  logic [CW-1:0]                      w_nret;
  logic                               w_issue;
  scoreboard_entry_t                  w_new;

  assign issue_ready_o    = (r_count != CW'(NR_ENTRIES));
  assign issue_trans_id_o = r_tail;
  assign empty_o          = (r_count == '0);
  assign w_issue          = issue_valid_i && issue_ready_o;

  // Head window: valid chains from port 0; retire only a valid ack prefix.
  always_comb begin
    logic w_cprev;
    logic w_rprev;
    w_idx   = '0;
    w_cval  = '0;
    w_ret   = '0;
    w_nret  = '0;
    w_cprev = 1'b1;
    w_rprev = 1'b1;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_idx[i]  = r_head + TB'(i);
      w_cval[i] = w_cprev && r_busy[w_idx[i]] && r_done[w_idx[i]];
      w_cprev   = w_cval[i];
      w_ret[i]  = w_rprev && commit_ack_i[i] && w_cval[i];
      w_rprev   = w_ret[i];
      w_nret    = w_nret + {{TB{1'b0}}, w_ret[i]};
    end
  end

  // Commit view straight from storage, valid overlaid.
  always_comb begin
    commit_instr_o = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      commit_instr_o[i]       = r_mem[w_idx[i]];
      commit_instr_o[i].valid = w_cval[i];
    end
  end

  // Fresh entry: id from tail, result and exception cleared.
  always_comb begin
    w_new          = issue_instr_i;
    w_new.valid    = 1'b0;
    w_new.trans_id = TRANS_ID_BITS'(r_tail);
    w_new.result   = '0;
    w_new.ex       = '0;
  end

  // Buffer state: flush beats writeback, retire and issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int e = 0; e < NR_ENTRIES; e++) r_mem[e] <= '0;
    end else if (flush_i) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && r_busy[wb_trans_id_i[p]]) begin
          r_mem[wb_trans_id_i[p]].result <= wb_result_i[p];
          r_mem[wb_trans_id_i[p]].ex     <= wb_ex_i[p];
          r_done[wb_trans_id_i[p]]       <= 1'b1;
        end
      end
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (w_ret[i]) begin
          r_busy[w_idx[i]] <= 1'b0;
          r_done[w_idx[i]] <= 1'b0;
        end
      end
      if (w_issue) begin
        r_mem[r_tail]  <= w_new;
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + 1'b1;
      end
      r_head  <= r_head + w_nret[TB-1:0];
      r_count <= r_count + {{TB{1'b0}}, w_issue} - w_nret;
    end
  end

`ifndef SYNTHESIS
  a_ack_on_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (commit_ack_i & ~w_cval) == '0);
  a_ack_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((({1'b0, commit_ack_i}) + (NR_COMMIT_PORTS+1)'(1))
      & {1'b0, commit_ack_i}) == '0);
`endif

endmodule
